// File: rtl/riscv_tag_policy_pipe_pkg.sv
// Shared definitions for the DIFT tag propagation policy decode.
// Contents:
//   - RISC-V major opcodes used by the tag policy
//   - tag class indices (bit positions in the one-hot class vector)
//   - tag_class_e: encoded class produced by the decoder
//   - tpr_field_lsb(): position of a class's enable field inside the TPR
package riscv_tag_policy_pipe_pkg;

    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    localparam int TAG_CLS_STORE  = 0;
    localparam int TAG_CLS_LOAD   = 1;
    localparam int TAG_CLS_ALU_R  = 2;
    localparam int TAG_CLS_ALU_I  = 3;
    localparam int TAG_CLS_BRANCH = 4;
    localparam int TAG_CLS_JUMP   = 5;
    localparam int TAG_N_CLS      = 6;

    typedef enum logic [2:0] {
        TAG_CLASS_STORE  = 3'd0,
        TAG_CLASS_LOAD   = 3'd1,
        TAG_CLASS_ALU_R  = 3'd2,
        TAG_CLASS_ALU_I  = 3'd3,
        TAG_CLASS_BRANCH = 3'd4,
        TAG_CLASS_JUMP   = 3'd5,
        TAG_CLASS_NONE   = 3'd7
    } tag_class_e;

    // Each class owns en_w consecutive TPR bits starting at cls*en_w.
    // The former fixed load/store enable bits are the class 0 field [1:0].
    function automatic int tpr_field_lsb(input int cls, input int en_w);
        return cls * en_w;
    endfunction

endpackage

// File: rtl/riscv_tag_policy_pipe_class_dec.sv
// riscv_tag_class_dec: combinational instruction-class decoder for the
// tag propagation policy. Shared with the WB-stage tag check.
// Ports:
//   instr_rdata_i  in  32       instruction word (only the opcode is used)
//   class_o        out N_CLASS  one-hot class, all zero for untracked opcodes
module riscv_tag_class_dec
    import riscv_tag_policy_pipe_pkg::*;
#(
    parameter int N_CLASS = 6
) (
    input  logic [31:0]        instr_rdata_i,
    output logic [N_CLASS-1:0] class_o
);

    tag_class_e           cls;
    logic [TAG_N_CLS-1:0] onehot;
    logic                 unused_instr_bits;

    // Operand fields are irrelevant to classification.
    assign unused_instr_bits = ^instr_rdata_i[31:7];

    always_comb begin
        case (instr_rdata_i[6:0])
            OPCODE_STORE:             cls = TAG_CLASS_STORE;
            OPCODE_LOAD:              cls = TAG_CLASS_LOAD;
            OPCODE_OP:                cls = TAG_CLASS_ALU_R;
            OPCODE_OPIMM:             cls = TAG_CLASS_ALU_I;
            OPCODE_BRANCH:            cls = TAG_CLASS_BRANCH;
            OPCODE_JAL, OPCODE_JALR:  cls = TAG_CLASS_JUMP;
            default:                  cls = TAG_CLASS_NONE;
        endcase
    end

    always_comb begin
        onehot = '0;
        for (int i = 0; i < TAG_N_CLS; i++) begin
            onehot[i] = (int'(cls) == i);
        end
    end

    // Classes the parameterisation does not carry are simply not reported.
    for (genvar g = 0; g < N_CLASS; g++) begin : g_cls
        if (g < TAG_N_CLS) begin : g_used
            assign class_o[g] = onehot[g];
        end else begin : g_spare
            assign class_o[g] = 1'b0;
        end
    end

endmodule

// File: rtl/riscv_tag_policy_pipe.sv
// riscv_tag_policy_pipe: one-entry ID->EX stage that decodes the DIFT tag
// policy of each instruction against the Tag Propagation Register (TPR).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   instr_valid_i/instr_rdata_i     instruction offered by ID
//   id_ready_o                      stage can take an instruction this cycle
//   ex_valid_o/ex_ready_i           held decode result handshake with EX
//   flush_i                         kill the held result (and any accept)
//   tpr_we_i/tpr_wdata_i, tpr_o     TPR CSR write and read-back
//   class_o, enable_o               one-hot class and tag enables
//   is_store_o, is_load_o           class shortcuts for the tag ALU
//   cnt_clr_i, cnt_o                saturating count of policy-active consumes
module riscv_tag_policy_pipe
    import riscv_tag_policy_pipe_pkg::*;
#(
    parameter int          EN_W      = 2,
    parameter int          N_CLASS   = 6,
    parameter logic [31:0] TPR_RESET = 32'h0,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid_i,
    input  logic [31:0]        instr_rdata_i,
    output logic               id_ready_o,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    input  logic               flush_i,
    input  logic               tpr_we_i,
    input  logic [31:0]        tpr_wdata_i,
    output logic [31:0]        tpr_o,
    output logic [N_CLASS-1:0] class_o,
    output logic [EN_W-1:0]    enable_o,
    output logic               is_store_o,
    output logic               is_load_o,
    input  logic               cnt_clr_i,
    output logic [CNT_W-1:0]   cnt_o
);

    localparam int FLD_W = N_CLASS * EN_W;

    logic               ex_valid_q, ex_valid_d;
    logic [N_CLASS-1:0] class_q, class_d;
    logic [EN_W-1:0]    enable_q, enable_d;
    logic               is_store_q, is_store_d;
    logic               is_load_q, is_load_d;
    logic [31:0]        tpr_q, tpr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_CLASS-1:0] dec_class;
    logic [EN_W-1:0]    dec_enable;
    logic [FLD_W-1:0]   tpr_fields;
    logic               accept;
    logic               consume;

    riscv_tag_class_dec #(
        .N_CLASS (N_CLASS)
    ) u_class_dec (
        .instr_rdata_i (instr_rdata_i),
        .class_o       (dec_class)
    );

    // Fields that would sit above bit 31 read as zero.
    if (FLD_W <= 32) begin : g_fld_fit
        assign tpr_fields = tpr_q[FLD_W-1:0];
    end else begin : g_fld_ext
        assign tpr_fields = {{(FLD_W-32){1'b0}}, tpr_q};
    end

    always_comb begin
        dec_enable = '0;
        for (int c = 0; c < N_CLASS; c++) begin
            if (dec_class[c]) begin
                dec_enable = dec_enable | tpr_fields[tpr_field_lsb(c, EN_W) +: EN_W];
            end
        end
    end

    assign id_ready_o = !ex_valid_q || ex_ready_i;
    assign accept     = instr_valid_i && id_ready_o;
    assign consume    = ex_valid_q && ex_ready_i;

    // Result outputs are zeroed whenever the stage is empty.
    always_comb begin
        ex_valid_d = ex_valid_q;
        class_d    = class_q;
        enable_d   = enable_q;
        is_store_d = is_store_q;
        is_load_d  = is_load_q;
        if (flush_i || (consume && !accept)) begin
            ex_valid_d = 1'b0;
            class_d    = '0;
            enable_d   = '0;
            is_store_d = 1'b0;
            is_load_d  = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
            class_d    = dec_class;
            enable_d   = dec_enable;
            is_store_d = dec_class[TAG_CLS_STORE];
            is_load_d  = dec_class[TAG_CLS_LOAD];
        end
    end

    // The decode above uses tpr_q, so a same-cycle write only affects
    // later accepts.
    always_comb begin
        tpr_d = tpr_q;
        if (tpr_we_i) begin
            tpr_d = tpr_wdata_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (consume && (enable_q != '0) && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            class_q    <= '0;
            enable_q   <= '0;
            is_store_q <= 1'b0;
            is_load_q  <= 1'b0;
            tpr_q      <= TPR_RESET;
            cnt_q      <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            class_q    <= class_d;
            enable_q   <= enable_d;
            is_store_q <= is_store_d;
            is_load_q  <= is_load_d;
            tpr_q      <= tpr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid_o = ex_valid_q;
    assign class_o    = class_q;
    assign enable_o   = enable_q;
    assign is_store_o = is_store_q;
    assign is_load_o  = is_load_q;
    assign tpr_o      = tpr_q;
    assign cnt_o      = cnt_q;

endmodule

// File: tb/tb_riscv_tag_policy_pipe.sv
module tb_riscv_tag_policy_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic        ex_ready;
    logic        flush;
    logic        tpr_we;
    logic [31:0] tpr_wdata;
    logic        cnt_clr;

    logic        id_ready, ex_valid, is_store, is_load;
    logic [31:0] tpr;
    logic [5:0]  cls;
    logic [1:0]  en;
    logic [15:0] cnt;

    logic        id_ready4, ex_valid4, is_store4, is_load4;
    logic [31:0] tpr4;
    logic [5:0]  cls4;
    logic [1:0]  en4;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;

    // reference model: the held instruction and architectural state
    bit          m_valid;
    int          m_cls;
    int          m_en;
    logic [31:0] m_tpr;
    int          m_cnt;

    always #5 clk = ~clk;

    riscv_tag_policy_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .instr_rdata_i(instr),
        .id_ready_o(id_ready), .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .flush_i(flush),
        .tpr_we_i(tpr_we), .tpr_wdata_i(tpr_wdata), .tpr_o(tpr), .class_o(cls), .enable_o(en),
        .is_store_o(is_store), .is_load_o(is_load), .cnt_clr_i(cnt_clr), .cnt_o(cnt)
    );

    riscv_tag_policy_pipe #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(instr_valid), .instr_rdata_i(instr),
        .id_ready_o(id_ready4), .ex_valid_o(ex_valid4), .ex_ready_i(ex_ready), .flush_i(flush),
        .tpr_we_i(tpr_we), .tpr_wdata_i(tpr_wdata), .tpr_o(tpr4), .class_o(cls4), .enable_o(en4),
        .is_store_o(is_store4), .is_load_o(is_load4), .cnt_clr_i(cnt_clr), .cnt_o(cnt4)
    );

    function automatic int op_class(input logic [31:0] w);
        case (w[6:0])
            7'h23:        return 0;
            7'h03:        return 1;
            7'h33:        return 2;
            7'h13:        return 3;
            7'h63:        return 4;
            7'h6F, 7'h67: return 5;
            default:      return -1;
        endcase
    endfunction

    function automatic logic [5:0] exp_class();
        return (m_valid && m_cls >= 0) ? 6'(1 << m_cls) : 6'h0;
    endfunction

    function automatic logic [15:0] exp_cnt16();
        return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    endfunction

    function automatic logic [3:0] exp_cnt4();
        return (m_cnt > 15) ? 4'hF : 4'(m_cnt);
    endfunction

    // Advance one clock and apply the policy rules to the model.
    task automatic step();
        bit          rdy, acc, cons, n_valid;
        int          n_cls, n_en, n_cnt;
        logic [31:0] n_tpr;
        rdy     = !m_valid || ex_ready;
        acc     = instr_valid && rdy;
        cons    = m_valid && ex_ready;
        n_valid = m_valid; n_cls = m_cls; n_en = m_en;
        n_tpr   = tpr_we ? tpr_wdata : m_tpr;
        n_cnt   = m_cnt;
        if (cnt_clr) n_cnt = 0;
        else if (cons && m_en != 0) n_cnt = m_cnt + 1;
        if (flush) begin
            n_valid = 0; n_cls = -1; n_en = 0;
        end else if (acc) begin
            n_valid = 1;
            n_cls   = op_class(instr);
            n_en    = (n_cls < 0) ? 0 : int'((m_tpr >> (2 * n_cls)) & 32'h3);
        end else if (cons) begin
            n_valid = 0;
        end
        if (!rst_n) begin
            n_valid = 0; n_cls = -1; n_en = 0; n_tpr = 32'h0; n_cnt = 0;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_cls = n_cls; m_en = n_en; m_tpr = n_tpr; m_cnt = n_cnt;
    endtask

    task automatic idle();
        instr_valid = 0; instr = 32'h0; ex_ready = 1; flush = 0;
        tpr_we = 0; tpr_wdata = 32'h0; cnt_clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        step(); step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ex_valid); end
        checks++; if (cls !== 6'h0 || en !== 2'h0) begin errors++; $display("FAIL reset_dec got cls %b en %b exp 0", cls, en); end
        checks++; if (is_store !== 1'b0 || is_load !== 1'b0) begin errors++; $display("FAIL reset_ldst got %0b%0b exp 00", is_store, is_load); end
        checks++; if (tpr !== 32'h0 || cnt !== 16'h0) begin errors++; $display("FAIL reset_tpr_cnt got %h %h exp 0", tpr, cnt); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", id_ready); end
        rst_n = 1;
    endtask

    task automatic test_store();
        tpr_we = 1; tpr_wdata = 32'h0000_0003;
        step();
        tpr_we = 0;
        checks++; if (tpr !== 32'h3) begin errors++; $display("FAIL tpr_write got %h exp 00000003", tpr); end
        instr = 32'h00A12023; instr_valid = 1; ex_ready = 1;
        step();
        instr_valid = 0;
        checks++; if (ex_valid !== 1'b1 || cls !== 6'b000001) begin errors++; $display("FAIL store_class got v%0b %b exp v1 000001", ex_valid, cls); end
        checks++; if (en !== 2'b11 || is_store !== 1'b1 || is_load !== 1'b0) begin errors++; $display("FAIL store_en got %b st%0b ld%0b exp 11 st1 ld0", en, is_store, is_load); end
        step();
        checks++; if (cnt !== 16'd1 || ex_valid !== 1'b0) begin errors++; $display("FAIL store_cnt got cnt %0d v%0b exp 1 v0", cnt, ex_valid); end
    endtask

    task automatic test_tpr_shadow();
        instr = 32'h00B50533; instr_valid = 1; ex_ready = 1;
        tpr_we = 1; tpr_wdata = 32'h0000_0C30;
        step();
        tpr_we = 0;
        checks++; if (cls !== 6'b000100 || en !== 2'b00) begin errors++; $display("FAIL shadow_old got %b %b exp 000100 00", cls, en); end
        step();
        instr_valid = 0;
        checks++; if (ex_valid !== 1'b1 || en !== 2'b11) begin errors++; $display("FAIL shadow_new got v%0b %b exp v1 11", ex_valid, en); end
        checks++; if (cnt !== exp_cnt16()) begin errors++; $display("FAIL shadow_cnt got %0d exp %0d", cnt, exp_cnt16()); end
        step();
    endtask

    task automatic test_stall();
        logic [5:0] hold_cls;
        logic [1:0] hold_en;
        tpr_we = 1; tpr_wdata = 32'h0000_03C0;
        step();
        tpr_we = 0;
        instr = 32'h00150513; instr_valid = 1; ex_ready = 0;
        step();
        hold_cls = cls; hold_en = en;
        checks++; if (cls !== 6'b001000 || en !== 2'b11) begin errors++; $display("FAIL stall_first got %b %b exp 001000 11", cls, en); end
        instr = 32'h00B50463;
        for (int i = 0; i < 3; i++) begin
            checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready cyc %0d got %0b exp 0", i, id_ready); end
            step();
            checks++; if (ex_valid !== 1'b1 || cls !== hold_cls || en !== hold_en) begin errors++; $display("FAIL stall_hold cyc %0d got v%0b %b %b exp v1 %b %b", i, ex_valid, cls, en, hold_cls, hold_en); end
        end
        ex_ready = 1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %0b exp 1", id_ready); end
        step();
        instr_valid = 0;
        checks++; if (ex_valid !== 1'b1 || cls !== 6'b010000 || en !== 2'b11) begin errors++; $display("FAIL b2b got v%0b %b %b exp v1 010000 11", ex_valid, cls, en); end
        step();
    endtask

    task automatic test_flush();
        logic [15:0] cnt_before;
        tpr_we = 1; tpr_wdata = 32'h0000_000C;
        step();
        tpr_we = 0;
        cnt_before = cnt;
        instr = 32'h00052583; instr_valid = 1; flush = 1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", id_ready); end
        step();
        flush = 0; instr_valid = 0;
        checks++; if (ex_valid !== 1'b0 || en !== 2'b00 || cls !== 6'h0 || is_load !== 1'b0) begin errors++; $display("FAIL flush_drop got v%0b %b %b exp v0 00 0", ex_valid, en, cls); end
        step();
        checks++; if (cnt !== cnt_before) begin errors++; $display("FAIL flush_cnt got %0d exp %0d", cnt, cnt_before); end
    endtask

    task automatic test_cnt_sat();
        cnt_clr = 1;
        tpr_we = 1; tpr_wdata = 32'hFFFF_FFFF;
        step();
        cnt_clr = 0; tpr_we = 0;
        instr = 32'h00A12023; instr_valid = 1; ex_ready = 1;
        for (int i = 0; i < 18; i++) step();
        checks++; if (cnt4 !== 4'hF) begin errors++; $display("FAIL sat4 got %h exp F", cnt4); end
        checks++; if (cnt !== 16'd17) begin errors++; $display("FAIL sat16 got %0d exp 17", cnt); end
        cnt_clr = 1;
        step();
        cnt_clr = 0; instr_valid = 0;
        checks++; if (cnt !== 16'h0 || cnt4 !== 4'h0) begin errors++; $display("FAIL clr_pri got %0d %0d exp 0 0", cnt, cnt4); end
        step();
        checks++; if (cnt !== exp_cnt16() || cnt4 !== exp_cnt4()) begin errors++; $display("FAIL clr_after got %0d %0d exp %0d %0d", cnt, cnt4, exp_cnt16(), exp_cnt4()); end
    endtask

    task automatic test_reset_mid();
        instr = 32'h00A12023; instr_valid = 1; ex_ready = 0;
        step();
        instr_valid = 1;
        rst_n = 0;
        step();
        rst_n = 1; instr_valid = 0; ex_ready = 1;
        checks++; if (ex_valid !== 1'b0 || cls !== 6'h0 || en !== 2'h0 || is_store !== 1'b0) begin errors++; $display("FAIL rst_mid_dec got v%0b %b %b st%0b exp all 0", ex_valid, cls, en, is_store); end
        checks++; if (tpr !== 32'h0 || cnt !== 16'h0 || cnt4 !== 4'h0) begin errors++; $display("FAIL rst_mid_state got %h %0d %0d exp 0", tpr, cnt, cnt4); end
    endtask

    task automatic test_unknown();
        tpr_we = 1; tpr_wdata = 32'hFFFF_FFFF;
        step();
        tpr_we = 0;
        instr = 32'h0000007F; instr_valid = 1; ex_ready = 1;
        step();
        instr_valid = 0;
        checks++; if (ex_valid !== 1'b1 || cls !== 6'h0 || en !== 2'h0 || is_store !== 1'b0 || is_load !== 1'b0) begin errors++; $display("FAIL unknown got v%0b %b %b exp v1 0 0", ex_valid, cls, en); end
        step();
        checks++; if (cnt !== 16'h0) begin errors++; $display("FAIL unknown_cnt got %0d exp 0", cnt); end
    endtask

    task automatic test_random();
        logic [6:0]  ops [8] = '{7'h23, 7'h03, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37};
        logic [31:0] r;
        logic [5:0]  ec;
        for (int i = 0; i < 600; i++) begin
            r           = $urandom();
            instr       = {r[31:7], ops[$urandom_range(0, 7)]};
            instr_valid = ($urandom_range(0, 3) != 0);
            ex_ready    = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            tpr_we      = ($urandom_range(0, 7) == 0);
            tpr_wdata   = $urandom();
            cnt_clr     = ($urandom_range(0, 39) == 0);
            rst_n       = ($urandom_range(0, 79) != 0);
            step();
            ec = exp_class();
            checks++; if (ex_valid !== m_valid || ex_valid4 !== m_valid) begin errors++; $display("FAIL rnd_valid i%0d got %0b %0b exp %0b", i, ex_valid, ex_valid4, m_valid); end
            checks++; if (tpr !== m_tpr) begin errors++; $display("FAIL rnd_tpr i%0d got %h exp %h", i, tpr, m_tpr); end
            checks++; if (cnt !== exp_cnt16() || cnt4 !== exp_cnt4()) begin errors++; $display("FAIL rnd_cnt i%0d got %0d %0d exp %0d %0d", i, cnt, cnt4, exp_cnt16(), exp_cnt4()); end
            if (m_valid) begin
                checks++; if (cls !== ec || en !== 2'(m_en)) begin errors++; $display("FAIL rnd_dec i%0d got %b %b exp %b %b", i, cls, en, ec, 2'(m_en)); end
                checks++; if (is_store !== ec[0] || is_load !== ec[1]) begin errors++; $display("FAIL rnd_ldst i%0d got %0b%0b exp %0b%0b", i, is_store, is_load, ec[0], ec[1]); end
            end
            checks++; if (id_ready !== (!m_valid || ex_ready)) begin errors++; $display("FAIL rnd_ready i%0d got %0b exp %0b", i, id_ready, (!m_valid || ex_ready)); end
        end
        rst_n = 1; idle();
    endtask

    initial begin
        m_valid = 0; m_cls = -1; m_en = 0; m_tpr = 32'h0; m_cnt = 0;
        rst_n = 0; idle();
        test_reset();
        test_store();
        test_tpr_shadow();
        test_stall();
        test_flush();
        test_cnt_sat();
        test_reset_mid();
        test_unknown();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
